// File: rtl/bp_stall_profile_pkg.sv
// Definitions shared by the stall profiler, its readout engine and the host decoder:
// record FSM states, header magic and header field layout.
package bp_stall_profile_pkg;

   typedef enum logic [1:0] {
      e_idle,
      e_header,
      e_body,
      e_trailer
   } bp_stall_drain_state_e;

   localparam logic [7:0] stall_hdr_magic_gp     = 8'hB5;
   localparam int         stall_num_reasons_gp   = 24;
   localparam int         stall_hdr_hart_width_gp = 8;
   localparam int         stall_hdr_seq_width_gp  = 16;

   // Header word, MSB first: magic, hart id, sequence number
   typedef struct packed {
      logic [7:0]                          magic;
      logic [stall_hdr_hart_width_gp-1:0]  hart;
      logic [stall_hdr_seq_width_gp-1:0]   seq;
   } bp_stall_hdr_s;

   function automatic logic [31:0] stall_hdr_pack(
      input logic [stall_hdr_hart_width_gp-1:0] hart,
      input logic [stall_hdr_seq_width_gp-1:0]  seq
   );
      bp_stall_hdr_s hdr;
      hdr.magic = stall_hdr_magic_gp;
      hdr.hart  = hart;
      hdr.seq   = seq;
      return hdr;
   endfunction

endpackage

// File: rtl/bp_stall_profile_drain_bsg.sv
// Small basejump-style helpers used by the drain engine: a clearable up-counter
// for the body word index and a one-hot-free word select mux.
module bsg_counter_clear_up #(
   parameter int max_val_p  = 23,
   parameter int init_val_p = 0,
   localparam int ptr_width_lp = (max_val_p < 1) ? 1 : $clog2(max_val_p + 1)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    clear_i,
   input  logic                    up_i,
   output logic [ptr_width_lp-1:0] count_o
);

   logic [ptr_width_lp-1:0] count_q, count_d;

   // Clear and up in the same cycle yields 1, matching the basejump counter
   always_comb begin
      count_d = count_q;
      if (clear_i)
         count_d = '0;
      if (up_i)
         count_d = count_d + ptr_width_lp'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         count_q <= ptr_width_lp'(init_val_p);
      else
         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

module bsg_mux #(
   parameter int width_p = 32,
   parameter int els_p   = 24,
   localparam int lg_els_lp = (els_p < 2) ? 1 : $clog2(els_p)
) (
   input  logic [els_p-1:0][width_p-1:0] data_i,
   input  logic [lg_els_lp-1:0]          sel_i,
   output logic [width_p-1:0]            data_o
);

   assign data_o = data_i[sel_i];

endmodule

// File: rtl/bp_stall_profile_drain.sv
// Snapshot-and-stream readout of the per-core stall-reason counter bank:
// header, one word per reason, XOR checksum trailer over a valid/ready channel.
module bp_stall_profile_drain
   import bp_stall_profile_pkg::*;
#(
   parameter int num_reasons_p = stall_num_reasons_gp,
   parameter int cnt_width_p   = 32,
   parameter int hart_width_p  = 8
) (
   input  logic                                 clk_i,
   input  logic                                 reset_n_i,
   input  logic [hart_width_p-1:0]              mhartid_i,
   input  logic [num_reasons_p*cnt_width_p-1:0] cnt_i,
   input  logic                                 snap_req_i,
   input  logic                                 clear_en_i,
   output logic                                 clear_o,
   output logic [cnt_width_p-1:0]               data_o,
   output logic                                 v_o,
   input  logic                                 ready_i,
   output logic                                 busy_o,
   output logic                                 overrun_o,
   output logic [15:0]                          seq_o
);

   localparam int idx_width_lp = (num_reasons_p < 2) ? 1 : $clog2(num_reasons_p);

   bp_stall_drain_state_e state_q, state_d;
   logic [15:0]           seq_q, seq_d;
   logic                  overrun_q, overrun_d;

   logic [num_reasons_p-1:0][cnt_width_p-1:0] snap_q, snap_d;
   logic [cnt_width_p-1:0]                    checksum_q, checksum_d;

   logic [idx_width_lp-1:0] idx;
   logic [cnt_width_p-1:0]  body_word;
   logic                    capture, hs, idx_last;

   function automatic logic [cnt_width_p-1:0] xor_words(
      input logic [num_reasons_p*cnt_width_p-1:0] bank
   );
      logic [cnt_width_p-1:0] acc;
      acc = '0;
      for (int k = 0; k < num_reasons_p; k++)
         acc = acc ^ bank[k*cnt_width_p +: cnt_width_p];
      return acc;
   endfunction

   assign capture  = (state_q == e_idle) & snap_req_i;
   assign v_o      = (state_q != e_idle);
   assign busy_o   = v_o;
   assign hs       = v_o & ready_i;
   assign idx_last = (idx == idx_width_lp'(num_reasons_p - 1));

   // Source clears on the capture edge so no event is lost or counted twice
   assign clear_o  = reset_n_i & capture & clear_en_i;

   always_comb begin
      state_d   = state_q;
      seq_d     = seq_q;
      overrun_d = overrun_q;
      unique case (state_q)
         e_idle: begin
            if (snap_req_i) begin
               state_d   = e_header;
               seq_d     = seq_q + 16'd1;
               overrun_d = 1'b0;
            end
         end
         e_header:  if (hs)             state_d = e_body;
         e_body:    if (hs && idx_last) state_d = e_trailer;
         e_trailer: if (hs)             state_d = e_idle;
         default:                       state_d = e_idle;
      endcase
      if ((state_q != e_idle) && snap_req_i)
         overrun_d = 1'b1;
   end

   always_comb begin
      snap_d     = snap_q;
      checksum_d = checksum_q;
      if (capture) begin
         snap_d     = cnt_i;
         checksum_d = xor_words(cnt_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q   <= e_idle;
         seq_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         seq_q     <= seq_d;
         overrun_q <= overrun_d;
      end
   end

   // Snapshot payload only matters while a record is open, so it carries no reset
   always_ff @(posedge clk_i) begin
      snap_q     <= snap_d;
      checksum_q <= checksum_d;
   end

   bsg_counter_clear_up #(
      .max_val_p (num_reasons_p - 1),
      .init_val_p(0)
   ) idx_ctr (
      .clk_i  (clk_i),
      .reset_i(~reset_n_i),
      .clear_i((state_q == e_header) & hs),
      .up_i   ((state_q == e_body) & hs & ~idx_last),
      .count_o(idx)
   );

   bsg_mux #(
      .width_p(cnt_width_p),
      .els_p  (num_reasons_p)
   ) word_mux (
      .data_i(snap_q),
      .sel_i (idx),
      .data_o(body_word)
   );

   always_comb begin
      data_o = '0;
      unique case (state_q)
         e_header:  data_o = cnt_width_p'(stall_hdr_pack(8'(mhartid_i), seq_q));
         e_body:    data_o = body_word;
         e_trailer: data_o = checksum_q;
         default:   data_o = '0;
      endcase
   end

   assign overrun_o = overrun_q;
   assign seq_o     = seq_q;

endmodule

// File: tb/tb_bp_stall_profile_drain.sv
// Bench for bp_stall_profile_drain: directed records queued into a scoreboard,
// popped by a negedge monitor on every accepted beat.
module tb_bp_stall_profile_drain;

   localparam int NR = 24;
   localparam int CW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset_n_i;
   logic [7:0]       mhartid_i;
   logic [NR*CW-1:0] cnt_i;
   logic             snap_req_i, clear_en_i, clear_o;
   logic [CW-1:0]    data_o;
   logic             v_o, ready_i, busy_o, overrun_o;
   logic [15:0]      seq_o;

   logic [CW-1:0] cnt_arr [NR];

   always_comb begin
      cnt_i = '0;
      for (int k = 0; k < NR; k++)
         cnt_i[k*CW +: CW] = cnt_arr[k];
   end

   bp_stall_profile_drain dut (
      .clk_i     (clk),
      .reset_n_i (reset_n_i),
      .mhartid_i (mhartid_i),
      .cnt_i     (cnt_i),
      .snap_req_i(snap_req_i),
      .clear_en_i(clear_en_i),
      .clear_o   (clear_o),
      .data_o    (data_o),
      .v_o       (v_o),
      .ready_i   (ready_i),
      .busy_o    (busy_o),
      .overrun_o (overrun_o),
      .seq_o     (seq_o)
   );

   logic [CW-1:0] sb [$];
   int            checks = 0;
   int            errors = 0;
   logic          stall_pend = 1'b0;
   logic [CW-1:0] stall_data = '0;
   logic [CW-1:0] xr;

   task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: every accepted beat must match the head of the scoreboard;
   // a stalled beat must hold valid and data until accepted.
   always @(negedge clk) begin
      if (!reset_n_i) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            chk("hold_valid", {31'd0, v_o}, 32'd1);
            chk("hold_data", data_o, stall_data);
         end
         if (v_o && ready_i) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat actual=%h required=none", data_o);
            end else begin
               chk("beat", data_o, sb.pop_front());
            end
         end
         stall_pend = v_o && !ready_i;
         stall_data = data_o;
      end
   end

   task automatic push_record(input logic [15:0] seq, output logic [CW-1:0] x);
      x = '0;
      sb.push_back({8'hB5, mhartid_i, seq});
      for (int k = 0; k < NR; k++) begin
         sb.push_back(cnt_arr[k]);
         x = x ^ cnt_arr[k];
      end
   endtask

   // Starts at posedge+1 with the DUT idle; returns at the negedge after capture.
   task automatic request(input logic clr, input logic [15:0] exp_seq, input string nm);
      snap_req_i = 1'b1;
      clear_en_i = clr;
      @(negedge clk);
      chk({nm, "_clear_o"}, {31'd0, clear_o}, {31'd0, clr});
      @(posedge clk);
      #1 snap_req_i = 1'b0;
      clear_en_i = 1'b0;
      @(negedge clk);
      chk({nm, "_hdr_valid"}, {31'd0, v_o}, 32'd1);
      chk({nm, "_busy"}, {31'd0, busy_o}, 32'd1);
      chk({nm, "_seq_o"}, {16'd0, seq_o}, {16'd0, exp_seq});
   endtask

   task automatic wait_done(input string nm, input bit rnd);
      int n = 0;
      while ((sb.size() != 0 || busy_o) && n < 500) begin
         @(posedge clk);
         #1;
         if (rnd) ready_i = 1'($urandom_range(0, 1));
         n++;
      end
      ready_i = 1'b1;
      chk(nm, {31'd0, n < 500}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n_i  = 1'b0;
      snap_req_i = 1'b1;
      clear_en_i = 1'b1;
      ready_i    = 1'b1;
      mhartid_i  = 8'h3C;
      for (int k = 0; k < NR; k++) cnt_arr[k] = CW'(3 * k + 1);

      // Reset state, with a request and clear enable present while reset is held
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_clear_o", {31'd0, clear_o}, 32'd0);
      chk("rst_v_o", {31'd0, v_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_overrun", {31'd0, overrun_o}, 32'd0);
      chk("rst_seq", {16'd0, seq_o}, 32'd0);
      chk("rst_data", data_o, 32'd0);
      @(posedge clk);
      #1 reset_n_i = 1'b1;
      snap_req_i = 1'b0;
      clear_en_i = 1'b0;
      @(posedge clk);
      #1;

      // Record 1: counter k = 3k+1, no clear; checksum of 1,4,...,70 is 0x50
      push_record(16'd1, xr);
      sb.push_back(32'h0000_0050);
      request(1'b0, 16'd1, "r1");
      chk("r1_first_word", data_o, 32'hB53C_0001);
      wait_done("r1_done", 1'b0);

      // Record 2: clear on capture, random backpressure, bank changes mid-record
      for (int k = 0; k < NR; k++) cnt_arr[k] = CW'(100 + 7 * k);
      push_record(16'd2, xr);
      sb.push_back(xr);
      request(1'b1, 16'd2, "r2");
      chk("r2_clear_drop", {31'd0, clear_o}, 32'd0);
      for (int k = 0; k < NR; k++) cnt_arr[k] = CW'(k);
      wait_done("r2_done", 1'b1);

      // Record 3: post-clear counts, different hart, request pulsed mid-body
      mhartid_i = 8'hA7;
      push_record(16'd3, xr);
      sb.push_back(xr);
      @(posedge clk);
      #1;
      request(1'b0, 16'd3, "r3");
      repeat (5) @(posedge clk);
      #1 snap_req_i = 1'b1;
      clear_en_i = 1'b1;
      @(negedge clk);
      chk("ovr_no_clear", {31'd0, clear_o}, 32'd0);
      @(posedge clk);
      #1 snap_req_i = 1'b0;
      clear_en_i = 1'b0;
      @(negedge clk);
      chk("ovr_set", {31'd0, overrun_o}, 32'd1);
      wait_done("r3_done", 1'b0);
      chk("ovr_sticky", {31'd0, overrun_o}, 32'd1);
      mhartid_i = 8'h3C;

      // Records 4 and 5: request held high, one idle cycle between records
      push_record(16'd4, xr);
      sb.push_back(xr);
      push_record(16'd5, xr);
      sb.push_back(xr);
      @(posedge clk);
      #1 snap_req_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("b2b_ovr_clr", {31'd0, overrun_o}, 32'd0);
      chk("b2b_seq4", {16'd0, seq_o}, 32'd4);
      @(posedge clk);
      @(negedge clk);
      chk("b2b_ovr_set", {31'd0, overrun_o}, 32'd1);
      repeat (25) @(posedge clk);
      @(negedge clk);
      chk("b2b_gap_v", {31'd0, v_o}, 32'd0);
      chk("b2b_gap_busy", {31'd0, busy_o}, 32'd0);
      @(posedge clk);
      #1 snap_req_i = 1'b0;
      @(negedge clk);
      chk("b2b_r5_v", {31'd0, v_o}, 32'd1);
      chk("b2b_seq5", {16'd0, seq_o}, 32'd5);
      chk("b2b_r5_ovr", {31'd0, overrun_o}, 32'd0);
      wait_done("b2b_done", 1'b0);

      // Record 6 aborted by a one-cycle reset mid-body
      push_record(16'd6, xr);
      sb.push_back(xr);
      @(posedge clk);
      #1;
      request(1'b0, 16'd6, "r6");
      repeat (6) @(posedge clk);
      #1 reset_n_i = 1'b0;
      sb.delete();
      @(posedge clk);
      #1 reset_n_i = 1'b1;
      @(negedge clk);
      chk("abort_v_o", {31'd0, v_o}, 32'd0);
      chk("abort_busy", {31'd0, busy_o}, 32'd0);
      chk("abort_seq", {16'd0, seq_o}, 32'd0);
      chk("abort_data", data_o, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_trailer", {31'd0, v_o}, 32'd0);

      // First record after reset carries seq 1
      push_record(16'd1, xr);
      sb.push_back(xr);
      request(1'b0, 16'd1, "r7");
      wait_done("r7_done", 1'b0);

      // Sequence wrap 0xFFFF -> 0x0000
      force dut.seq_q = 16'hFFFF;
      #1 release dut.seq_q;
      push_record(16'h0000, xr);
      sb.push_back(xr);
      request(1'b0, 16'h0000, "wrap");
      chk("wrap_hdr", data_o, 32'hB53C_0000);
      wait_done("wrap_done", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
